bru_rs: RTL and testbench

- Value-capturing reservation station for branch/jump uops; sits directly upstream of the branch resolution unit.
- Accepts renamed uops from dispatch and captures operand values as they arrive, at dispatch or later by snooping writeback/wakeup broadcasts.
- Issues the oldest entry whose operands are all ready, presenting the rs_uop_t plus rs1/rs2 values on a valid/ready handshake.

---
 rtl/bru_rs_if.sv | 65 ++++++
 rtl/bru_rs.sv | 179 +++++++++++++++++
 tb/tb_bru_rs.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bru_rs_if.sv
// bru_rs_pkg / bru_rs_if
// Purpose: uop types and the bus bundle shared by the branch reservation station
// and its neighbours (dispatch, writeback broadcast, branch resolution unit).
// Ports (bru_rs_if signals):
//   disp_valid/disp_ready/disp_uop/disp_rs*_rdy/disp_rs*_val : dispatch handshake
//   wk_valid/wk_prd/wk_data : NUM_WK writeback broadcast ports
//   flush                   : pipeline redirect, kills every entry
//   iss_valid/iss_ready/iss_uop/iss_rs*_val : issue handshake towards the BRU
//   occupancy               : number of valid entries
// Modports: master = upstream/downstream environment, slave = the RS.
package bru_rs_pkg;
  localparam int PHYS_W = 6;

  typedef struct packed {
    logic        uses_rs1;
    logic        uses_rs2;
    logic [3:0]  br_op;
    logic [31:0] pc;
    logic [31:0] imm;
  } rs_bundle_t;

  typedef struct packed {
    rs_bundle_t        bundle;
    logic [PHYS_W-1:0] prs1;
    logic [PHYS_W-1:0] prs2;
    logic [PHYS_W-1:0] prd;
  } rs_uop_t;
endpackage

interface bru_rs_if #(
  parameter int DEPTH  = 4,
  parameter int NUM_WK = 2
);
  import bru_rs_pkg::*;

  logic                                 disp_valid;
  logic                                 disp_ready;
  rs_uop_t                              disp_uop;
  logic                                 disp_rs1_rdy;
  logic [31:0]                          disp_rs1_val;
  logic                                 disp_rs2_rdy;
  logic [31:0]                          disp_rs2_val;
  logic [NUM_WK-1:0]                    wk_valid;
  logic [NUM_WK-1:0][PHYS_W-1:0]        wk_prd;
  logic [NUM_WK-1:0][31:0]              wk_data;
  logic                                 flush;
  logic                                 iss_valid;
  logic                                 iss_ready;
  rs_uop_t                              iss_uop;
  logic [31:0]                          iss_rs1_val;
  logic [31:0]                          iss_rs2_val;
  logic [$clog2(DEPTH):0]               occupancy;

  modport master (
    output disp_valid, disp_uop, disp_rs1_rdy, disp_rs1_val, disp_rs2_rdy, disp_rs2_val,
    output wk_valid, wk_prd, wk_data, flush, iss_ready,
    input  disp_ready, iss_valid, iss_uop, iss_rs1_val, iss_rs2_val, occupancy
  );

  modport slave (
    input  disp_valid, disp_uop, disp_rs1_rdy, disp_rs1_val, disp_rs2_rdy, disp_rs2_val,
    input  wk_valid, wk_prd, wk_data, flush, iss_ready,
    output disp_ready, iss_valid, iss_uop, iss_rs1_val, iss_rs2_val, occupancy
  );
endinterface

// File: rtl/bru_rs.sv
// bru_rs
// Purpose: value-capturing reservation station for branch/jump uops. Captures
// operands at dispatch or by snooping writeback broadcasts and issues the oldest
// entry whose operands are both ready.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : bru_rs_if.slave (dispatch, wakeup, flush, issue, occupancy)
module bru_rs
  import bru_rs_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int NUM_WK = 2
) (
  input logic     clk,
  input logic     rst_n,
  bru_rs_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] RANK_ONE = IDX_W'(1);

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
  } wk_res_t;

  // Tag match against all broadcast ports; the lowest port index wins.
  function automatic wk_res_t wk_lookup(
    input logic [PHYS_W-1:0]             tag,
    input logic [NUM_WK-1:0]             valid,
    input logic [NUM_WK-1:0][PHYS_W-1:0] prd,
    input logic [NUM_WK-1:0][31:0]       data
  );
    wk_res_t res;
    logic    hit_p;
    res.hit  = 1'b0;
    res.data = 32'd0;
    for (int p = NUM_WK - 1; p >= 0; p--) begin
      hit_p    = valid[p] && (prd[p] == tag);
      res.data = hit_p ? data[p] : res.data;
      res.hit  = res.hit | hit_p;
    end
    return res;
  endfunction

  logic [DEPTH-1:0] valid_r;
  rs_uop_t          uop_r     [DEPTH];
  logic [DEPTH-1:0] rs1_rdy_r;
  logic [DEPTH-1:0] rs2_rdy_r;
  logic [31:0]      rs1_val_r [DEPTH];
  logic [31:0]      rs2_val_r [DEPTH];
  logic [IDX_W-1:0] rank_r    [DEPTH];   // 0 = oldest; ranks of valid entries are dense
  logic [OCC_W-1:0] occ_r;

  wk_res_t          disp_wk1_s;
  wk_res_t          disp_wk2_s;
  wk_res_t          ent_wk1_s [DEPTH];
  wk_res_t          ent_wk2_s [DEPTH];
  logic             disp_rs1_rdy_s;
  logic             disp_rs2_rdy_s;
  logic [31:0]      disp_rs1_val_s;
  logic [31:0]      disp_rs2_val_s;
  logic [DEPTH-1:0] cand_s;
  logic [DEPTH-1:0] take_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic             sel_found_s;
  logic [IDX_W-1:0] free_idx_s;
  logic             enq_s;
  logic             iss_fire_s;
  logic [OCC_W-1:0] occ_after_s;

  // Wakeup lookups for the dispatching uop and for every stored entry.
  always_comb begin
    disp_wk1_s = wk_lookup(bus.disp_uop.prs1, bus.wk_valid, bus.wk_prd, bus.wk_data);
    disp_wk2_s = wk_lookup(bus.disp_uop.prs2, bus.wk_valid, bus.wk_prd, bus.wk_data);
    for (int i = 0; i < DEPTH; i++) begin
      ent_wk1_s[i] = wk_lookup(uop_r[i].prs1, bus.wk_valid, bus.wk_prd, bus.wk_data);
      ent_wk2_s[i] = wk_lookup(uop_r[i].prs2, bus.wk_valid, bus.wk_prd, bus.wk_data);
    end
  end

  // Operand capture at dispatch: same-cycle broadcast beats the dispatch value.
  always_comb begin
    disp_rs1_rdy_s = !bus.disp_uop.bundle.uses_rs1 || bus.disp_rs1_rdy || disp_wk1_s.hit;
    disp_rs2_rdy_s = !bus.disp_uop.bundle.uses_rs2 || bus.disp_rs2_rdy || disp_wk2_s.hit;
    if (!bus.disp_uop.bundle.uses_rs1) begin
      disp_rs1_val_s = 32'd0;
    end else if (disp_wk1_s.hit) begin
      disp_rs1_val_s = disp_wk1_s.data;
    end else begin
      disp_rs1_val_s = bus.disp_rs1_val;
    end
    if (!bus.disp_uop.bundle.uses_rs2) begin
      disp_rs2_val_s = 32'd0;
    end else if (disp_wk2_s.hit) begin
      disp_rs2_val_s = disp_wk2_s.data;
    end else begin
      disp_rs2_val_s = bus.disp_rs2_val;
    end
  end

  // Oldest-ready select over registered state only, plus lowest free slot.
  always_comb begin
    cand_s      = valid_r & rs1_rdy_r & rs2_rdy_r;
    take_s      = {DEPTH{1'b0}};
    sel_idx_s   = {IDX_W{1'b0}};
    sel_found_s = 1'b0;
    free_idx_s  = {IDX_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      take_s[i]   = cand_s[i] && (!sel_found_s || (rank_r[i] < rank_r[sel_idx_s]));
      sel_idx_s   = take_s[i] ? IDX_W'(i) : sel_idx_s;
      sel_found_s = sel_found_s | take_s[i];
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      free_idx_s = !valid_r[i] ? IDX_W'(i) : free_idx_s;
    end
  end

  assign bus.disp_ready  = (occ_r < OCC_W'(DEPTH)) && !bus.flush;
  assign bus.iss_valid   = sel_found_s && !bus.flush;
  assign bus.iss_uop     = uop_r[sel_idx_s];
  assign bus.iss_rs1_val = rs1_val_r[sel_idx_s];
  assign bus.iss_rs2_val = rs2_val_r[sel_idx_s];
  assign bus.occupancy   = occ_r;

  assign enq_s       = bus.disp_valid && bus.disp_ready;
  assign iss_fire_s  = bus.iss_valid && bus.iss_ready;
  // Entries left after this cycle's issue; the new entry takes that rank.
  assign occ_after_s = occ_r - {{IDX_W{1'b0}}, iss_fire_s};

  // Entry state: reset, flush, wakeup capture, issue removal, enqueue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r   <= {DEPTH{1'b0}};
      rs1_rdy_r <= {DEPTH{1'b0}};
      rs2_rdy_r <= {DEPTH{1'b0}};
      occ_r     <= {OCC_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        uop_r[i]     <= {$bits(rs_uop_t){1'b0}};
        rs1_val_r[i] <= 32'd0;
        rs2_val_r[i] <= 32'd0;
        rank_r[i]    <= {IDX_W{1'b0}};
      end
    end else if (bus.flush) begin
      valid_r <= {DEPTH{1'b0}};
      occ_r   <= {OCC_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_r[i] && !rs1_rdy_r[i] && ent_wk1_s[i].hit) begin
          rs1_rdy_r[i] <= 1'b1;
          rs1_val_r[i] <= ent_wk1_s[i].data;
        end
        if (valid_r[i] && !rs2_rdy_r[i] && ent_wk2_s[i].hit) begin
          rs2_rdy_r[i] <= 1'b1;
          rs2_val_r[i] <= ent_wk2_s[i].data;
        end
        if (iss_fire_s && valid_r[i] && (rank_r[i] > rank_r[sel_idx_s])) begin
          rank_r[i] <= rank_r[i] - RANK_ONE;
        end
      end
      if (iss_fire_s) begin
        valid_r[sel_idx_s] <= 1'b0;
      end
      // The free slot is chosen from registered valid bits, so it never
      // collides with the entry issuing this cycle.
      if (enq_s) begin
        valid_r[free_idx_s]   <= 1'b1;
        uop_r[free_idx_s]     <= bus.disp_uop;
        rs1_rdy_r[free_idx_s] <= disp_rs1_rdy_s;
        rs1_val_r[free_idx_s] <= disp_rs1_val_s;
        rs2_rdy_r[free_idx_s] <= disp_rs2_rdy_s;
        rs2_val_r[free_idx_s] <= disp_rs2_val_s;
        rank_r[free_idx_s]    <= occ_after_s[IDX_W-1:0];
      end
      occ_r <= occ_after_s + {{IDX_W{1'b0}}, enq_s};
    end
  end
endmodule

// File: tb/tb_bru_rs.sv
// tb_bru_rs
// Purpose: self-checking bench for bru_rs. Expected issue records are pushed to
// a scoreboard when stimulus is driven and compared whenever the RS fires an
// issue; each scenario task also checks handshake/occupancy values inline.
module tb_bru_rs;
  import bru_rs_pkg::*;
  localparam int DEPTH  = 4;
  localparam int NUM_WK = 2;

  typedef struct packed {
    rs_uop_t     uop;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } iss_rec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bru_rs_if #(.DEPTH(DEPTH), .NUM_WK(NUM_WK)) bus ();
  bru_rs #(.DEPTH(DEPTH), .NUM_WK(NUM_WK)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  iss_rec_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Scoreboard: every fired issue must match the oldest pending expectation.
  always @(negedge clk) begin
    iss_rec_t exp_rec;
    if (rst_n && bus.iss_valid && bus.iss_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected got uop=%h rs1=%h rs2=%h want no issue",
                 bus.iss_uop, bus.iss_rs1_val, bus.iss_rs2_val);
      end else begin
        exp_rec = sb_q.pop_front();
        if ({bus.iss_uop, bus.iss_rs1_val, bus.iss_rs2_val} !== exp_rec) begin
          errors++;
          $display("FAIL issue_data got pc=%h rs1=%h rs2=%h want pc=%h rs1=%h rs2=%h",
                   bus.iss_uop.bundle.pc, bus.iss_rs1_val, bus.iss_rs2_val,
                   exp_rec.uop.bundle.pc, exp_rec.rs1, exp_rec.rs2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  function automatic rs_uop_t mk_uop(input logic [3:0] op, input logic u1, input logic u2,
                                     input logic [PHYS_W-1:0] p1, input logic [PHYS_W-1:0] p2,
                                     input logic [31:0] pc);
    rs_uop_t u;
    u                 = '0;
    u.bundle.br_op    = op;
    u.bundle.uses_rs1 = u1;
    u.bundle.uses_rs2 = u2;
    u.bundle.pc       = pc;
    u.bundle.imm      = pc + 32'd16;
    u.prs1            = p1;
    u.prs2            = p2;
    u.prd             = 6'd40;
    return u;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.disp_valid   = 1'b0;
    bus.disp_uop     = '0;
    bus.disp_rs1_rdy = 1'b0;
    bus.disp_rs1_val = 32'd0;
    bus.disp_rs2_rdy = 1'b0;
    bus.disp_rs2_val = 32'd0;
    bus.wk_valid     = 2'b00;
    bus.wk_prd       = '0;
    bus.wk_data      = '0;
    bus.flush        = 1'b0;
  endtask

  task automatic offer(input rs_uop_t u, input logic r1, input logic [31:0] v1,
                       input logic r2, input logic [31:0] v2);
    bus.disp_valid   = 1'b1;
    bus.disp_uop     = u;
    bus.disp_rs1_rdy = r1;
    bus.disp_rs1_val = v1;
    bus.disp_rs2_rdy = r2;
    bus.disp_rs2_val = v2;
  endtask

  task automatic push(input rs_uop_t u, input logic [31:0] v1, input logic [31:0] v2);
    sb_q.push_back({u, v1, v2});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.iss_ready = 1'b0;
    idle_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", bus.occupancy); end
    checks++;
    if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready got %b want 1", bus.disp_ready); end
    checks++;
    if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid got %b want 0", bus.iss_valid); end
    checks++;
    if ($isunknown({bus.iss_uop, bus.iss_rs1_val, bus.iss_rs2_val}) !== 1'b0) begin
      errors++; $display("FAIL reset_iss_x got X on iss outputs want defined");
    end
  endtask

  task automatic test_basic();
    rs_uop_t u;
    tick();
    u = mk_uop(4'd0, 1'b1, 1'b1, 6'd1, 6'd2, 32'h1000);
    offer(u, 1'b1, 32'd5, 1'b1, 32'd5);
    bus.iss_ready = 1'b1;
    push(u, 32'd5, 32'd5);
    @(negedge clk);
    checks++;
    if ({bus.disp_ready, bus.iss_valid, bus.occupancy} !== {1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL basic_disp got rdy=%b iv=%b occ=%0d want 1 0 0", bus.disp_ready, bus.iss_valid, bus.occupancy);
    end
    tick();
    bus.disp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.iss_valid, bus.occupancy} !== {1'b1, 3'd1}) begin
      errors++; $display("FAIL basic_issue got iv=%b occ=%0d want 1 1", bus.iss_valid, bus.occupancy);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.iss_valid, bus.occupancy} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL basic_after got iv=%b occ=%0d want 0 0", bus.iss_valid, bus.occupancy);
    end
  endtask

  task automatic test_fill();
    rs_uop_t fill_u [DEPTH];
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      fill_u[i] = mk_uop(4'd1, 1'b1, 1'b1, 6'(10 + i), 6'd0, 32'h2000 + 32'(i * 4));
      offer(fill_u[i], 1'b0, 32'hDEAD, 1'b1, 32'(i));
      @(negedge clk);
      checks++;
      if ({bus.disp_ready, bus.iss_valid} !== 2'b10) begin
        errors++; $display("FAIL fill_%0d got rdy=%b iv=%b want 1 0", i, bus.disp_ready, bus.iss_valid);
      end
      tick();
    end
    offer(mk_uop(4'd1, 1'b0, 1'b0, 6'd0, 6'd0, 32'h2FFF), 1'b1, 32'd0, 1'b1, 32'd0);
    @(negedge clk);
    checks++;
    if ({bus.disp_ready, bus.iss_valid, bus.occupancy} !== {1'b0, 1'b0, 3'd4}) begin
      errors++; $display("FAIL fill_full got rdy=%b iv=%b occ=%0d want 0 0 4", bus.disp_ready, bus.iss_valid, bus.occupancy);
    end
    tick();
    bus.disp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.occupancy !== 3'd4) begin errors++; $display("FAIL fill_reject got occ=%0d want 4", bus.occupancy); end
    tick();
    for (int k = 0; k < DEPTH; k++) begin
      bus.wk_valid   = 2'b01;
      bus.wk_prd[0]  = 6'(10 + k);
      bus.wk_data[0] = 32'h200 + 32'(k);
      push(fill_u[k], 32'h200 + 32'(k), 32'(k));
      tick();
    end
    bus.wk_valid = 2'b00;
    for (int c = 0; c < 10 && sb_q.size() != 0; c++) tick();
    @(negedge clk);
    checks++;
    if ({32'(sb_q.size()), bus.occupancy} !== {32'd0, 3'd0}) begin
      errors++; $display("FAIL fill_drain got pending=%0d occ=%0d want 0 0", sb_q.size(), bus.occupancy);
    end
  endtask

  task automatic test_wakeup();
    rs_uop_t u;
    rs_uop_t u2;
    tick();
    u = mk_uop(4'd2, 1'b1, 1'b1, 6'd7, 6'd3, 32'h3000);
    offer(u, 1'b0, 32'd0, 1'b1, 32'd3);
    tick();
    bus.disp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL wk_wait got iv=%b want 0", bus.iss_valid); end
    tick();
    bus.wk_valid   = 2'b10;
    bus.wk_prd[0]  = 6'd7;
    bus.wk_data[0] = 32'h999;
    bus.wk_prd[1]  = 6'd7;
    bus.wk_data[1] = 32'h100;
    push(u, 32'h100, 32'd3);
    @(negedge clk);
    checks++;
    if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL wk_same_cycle got iv=%b want 0", bus.iss_valid); end
    tick();
    bus.wk_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.iss_valid !== 1'b1) begin errors++; $display("FAIL wk_next_cycle got iv=%b want 1", bus.iss_valid); end
    tick();
    // Both ports hit: port 0 wins; the already-ready rs2 ignores the broadcast.
    u2 = mk_uop(4'd3, 1'b1, 1'b1, 6'd8, 6'd8, 32'h3100);
    offer(u2, 1'b0, 32'd0, 1'b1, 32'h55);
    tick();
    bus.disp_valid = 1'b0;
    bus.wk_valid   = 2'b11;
    bus.wk_prd[0]  = 6'd8;
    bus.wk_data[0] = 32'h111;
    bus.wk_prd[1]  = 6'd8;
    bus.wk_data[1] = 32'h222;
    push(u2, 32'h111, 32'h55);
    tick();
    bus.wk_valid = 2'b00;
    for (int c = 0; c < 6 && sb_q.size() != 0; c++) tick();
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL wk_drain got pending=%0d want 0", sb_q.size()); end
  endtask

  task automatic test_bypass();
    rs_uop_t u;
    tick();
    u = mk_uop(4'd4, 1'b1, 1'b0, 6'd9, 6'd0, 32'h4000);
    offer(u, 1'b0, 32'h1234, 1'b0, 32'hDEAD);
    bus.wk_valid   = 2'b01;
    bus.wk_prd[0]  = 6'd9;
    bus.wk_data[0] = 32'hABCD;
    push(u, 32'hABCD, 32'd0);
    @(negedge clk);
    checks++;
    if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL bypass_disp got iv=%b want 0", bus.iss_valid); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.iss_valid !== 1'b1) begin errors++; $display("FAIL bypass_issue got iv=%b want 1", bus.iss_valid); end
    tick();
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL bypass_drain got pending=%0d want 0", sb_q.size()); end
  endtask

  task automatic test_age();
    rs_uop_t a, b, c, d, e;
    a = mk_uop(4'd5, 1'b1, 1'b1, 6'd20, 6'd0, 32'h5000);
    b = mk_uop(4'd5, 1'b1, 1'b1, 6'd21, 6'd22, 32'h5004);
    offer(a, 1'b0, 32'd0, 1'b1, 32'd1);
    tick();
    offer(b, 1'b1, 32'hB1, 1'b1, 32'hB2);
    push(b, 32'hB1, 32'hB2);
    tick();
    bus.disp_valid = 1'b0;
    bus.wk_valid   = 2'b01;
    bus.wk_prd[0]  = 6'd20;
    bus.wk_data[0] = 32'hA1;
    push(a, 32'hA1, 32'd1);
    @(negedge clk);
    checks++;
    if (bus.iss_uop !== b) begin errors++; $display("FAIL age_b_first got pc=%h want pc=%h", bus.iss_uop.bundle.pc, b.bundle.pc); end
    tick();
    bus.wk_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.iss_uop !== a) begin errors++; $display("FAIL age_a_next got pc=%h want pc=%h", bus.iss_uop.bundle.pc, a.bundle.pc); end
    tick();
    bus.iss_ready = 1'b0;
    c = mk_uop(4'd6, 1'b1, 1'b0, 6'd1, 6'd0, 32'h5100);
    d = mk_uop(4'd6, 1'b0, 1'b1, 6'd0, 6'd2, 32'h5104);
    e = mk_uop(4'd6, 1'b1, 1'b1, 6'd3, 6'd4, 32'h5108);
    offer(c, 1'b1, 32'hC1, 1'b0, 32'hFFFF);
    push(c, 32'hC1, 32'd0);
    tick();
    offer(d, 1'b0, 32'hFFFF, 1'b1, 32'hD2);
    push(d, 32'd0, 32'hD2);
    tick();
    offer(e, 1'b1, 32'hE1, 1'b1, 32'hE2);
    push(e, 32'hE1, 32'hE2);
    bus.iss_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.iss_uop !== c) begin errors++; $display("FAIL age_c_oldest got pc=%h want pc=%h", bus.iss_uop.bundle.pc, c.bundle.pc); end
    tick();
    bus.disp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.occupancy !== 3'd2) begin errors++; $display("FAIL age_enq_iss got occ=%0d want 2", bus.occupancy); end
    for (int k = 0; k < 6 && sb_q.size() != 0; k++) tick();
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL age_drain got pending=%0d want 0", sb_q.size()); end
  endtask

  task automatic test_backpressure_flush();
    rs_uop_t f, g, h;
    tick();
    bus.iss_ready = 1'b0;
    f = mk_uop(4'd7, 1'b1, 1'b1, 6'd30, 6'd0, 32'h6000);
    g = mk_uop(4'd7, 1'b1, 1'b1, 6'd31, 6'd0, 32'h6004);
    h = mk_uop(4'd7, 1'b0, 1'b0, 6'd0, 6'd0, 32'h6008);
    offer(f, 1'b0, 32'd0, 1'b1, 32'hF2);
    tick();
    offer(g, 1'b1, 32'h61, 1'b1, 32'h62);
    tick();
    bus.disp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.iss_valid, bus.iss_uop} !== {1'b1, g}) begin
        errors++; $display("FAIL bp_hold_%0d got iv=%b pc=%h want 1 pc=%h", k, bus.iss_valid, bus.iss_uop.bundle.pc, g.bundle.pc);
      end
      tick();
    end
    bus.wk_valid   = 2'b01;
    bus.wk_prd[0]  = 6'd30;
    bus.wk_data[0] = 32'hF1;
    @(negedge clk);
    checks++;
    if (bus.iss_uop !== g) begin errors++; $display("FAIL bp_wk_same got pc=%h want pc=%h", bus.iss_uop.bundle.pc, g.bundle.pc); end
    tick();
    bus.wk_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({bus.iss_uop, bus.iss_rs1_val} !== {f, 32'hF1}) begin
      errors++; $display("FAIL bp_older got pc=%h rs1=%h want pc=%h rs1=f1", bus.iss_uop.bundle.pc, bus.iss_rs1_val, f.bundle.pc);
    end
    tick();
    bus.flush = 1'b1;
    offer(h, 1'b1, 32'd0, 1'b1, 32'd0);
    @(negedge clk);
    checks++;
    if ({bus.disp_ready, bus.iss_valid} !== 2'b00) begin
      errors++; $display("FAIL flush_cycle got rdy=%b iv=%b want 0 0", bus.disp_ready, bus.iss_valid);
    end
    tick();
    bus.flush      = 1'b0;
    bus.disp_valid = 1'b0;
    bus.iss_ready  = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.occupancy, bus.iss_valid, bus.disp_ready} !== {3'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL flush_after got occ=%0d iv=%b rdy=%b want 0 0 1", bus.occupancy, bus.iss_valid, bus.disp_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet_%0d got iv=%b want 0", k, bus.iss_valid); end
    end
  endtask

  task automatic test_reset_mid();
    rs_uop_t p, q;
    tick();
    bus.iss_ready = 1'b0;
    p = mk_uop(4'd8, 1'b0, 1'b0, 6'd0, 6'd0, 32'h7000);
    q = mk_uop(4'd8, 1'b0, 1'b0, 6'd0, 6'd0, 32'h7004);
    offer(p, 1'b1, 32'd0, 1'b1, 32'd0);
    tick();
    offer(q, 1'b1, 32'd0, 1'b1, 32'd0);
    tick();
    bus.disp_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.occupancy, bus.iss_valid} !== {3'd0, 1'b0}) begin
      errors++; $display("FAIL rst_mid got occ=%0d iv=%b want 0 0", bus.occupancy, bus.iss_valid);
    end
    tick();
    offer(q, 1'b1, 32'd0, 1'b1, 32'd0);
    push(q, 32'd0, 32'd0);
    tick();
    offer(p, 1'b1, 32'd0, 1'b1, 32'd0);
    push(p, 32'd0, 32'd0);
    tick();
    bus.disp_valid = 1'b0;
    bus.iss_ready  = 1'b1;
    for (int k = 0; k < 6 && sb_q.size() != 0; k++) tick();
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL rst_mid_drain got pending=%0d want 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_wakeup();
    test_bypass();
    test_age();
    test_backpressure_flush();
    test_reset_mid();
    tick();
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL final_pending got %0d want 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
